// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
package dmem_pkg;
    localparam int CPU_WIDTH       = 64;
    localparam int DMEM_WORD_BYTES = 8;
    localparam int DMEM_CNT_W      = 4;

    typedef enum logic [1:0] {IDLE, BUSY, ACCESS, RESP} dmem_state_e;

    typedef struct packed {
        logic                         wen;
        logic [CPU_WIDTH-1:0]         addr;
        logic [8*DMEM_WORD_BYTES-1:0] wdata;
        logic [DMEM_WORD_BYTES-1:0]   wstrb;
    } dmem_req_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: LSU-to-memory request/response bus; master is the LSU, slave the memory.
interface dmem_if;
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_wen;
    logic [dmem_pkg::CPU_WIDTH-1:0] req_addr;
    logic [63:0]                    req_wdata;
    logic [7:0]                     req_wstrb;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [63:0]                    rsp_rdata;
    logic                           rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 64 word store, per-byte write enable, registered read, no reset.
module dmem_array import dmem_pkg::*; #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic                       re,
    input  logic [DMEM_WORD_BYTES-1:0] be,
    input  logic [AW-1:0]              idx,
    input  logic [63:0]                wdata,
    output logic [63:0]                rdata
);
    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            for (int k = 0; k < DMEM_WORD_BYTES; k++)
                if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_rsp.sv
// dmem_rsp: fixed-latency data-memory responder for the LSU request bus.
// Optional DMEM_ERR_EN flags out-of-range addresses instead of wrapping them.
module dmem_rsp import dmem_pkg::*; #(
    parameter int                   DEPTH     = 1024,
    parameter int                   LATENCY   = 2,
    parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 64'h8000_0000
) (
    input logic   i_clk,
    input logic   i_rst_n,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t             req_q, req_d;
    logic [CPU_WIDTH-1:0]  off;
    logic [AW-1:0]         idx;
    logic                  err;
    logic [63:0]           arr_rdata;

    assign off = req_q.addr - BASE_ADDR;
    assign idx = AW'(off >> 3);
`ifdef DMEM_ERR_EN
    assign err = (off >> 3) >= CPU_WIDTH'(DEPTH);
`else
    assign err = 1'b0;
`endif

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (i_clk),
        .we    (state_q == ACCESS && req_q.wen && !err),
        .re    (state_q == ACCESS && !req_q.wen),
        .be    (req_q.wstrb),
        .idx   (idx),
        .wdata (req_q.wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                req_d   = '{bus.req_wen, bus.req_addr, bus.req_wdata, bus.req_wstrb};
                cnt_d   = DMEM_CNT_W'(LATENCY);
                state_d = (LATENCY == 0) ? ACCESS : BUSY;
            end
            BUSY: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == 1) ? ACCESS : BUSY;
            end
            ACCESS: state_d = RESP;
            RESP:   state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Read data sits in the array's output register and is only exposed for successful loads.
    assign bus.req_ready = state_q == IDLE && i_rst_n;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_rdata = (state_q == RESP && !req_q.wen && !err) ? arr_rdata : '0;
    assign bus.rsp_err   = state_q == RESP && err;
endmodule

// File: tb/tb_dmem_rsp.sv
// tb_dmem_rsp: directed checks of dmem_rsp at LATENCY=2 (dut_a) and LATENCY=0 (dut_b).
module tb_dmem_rsp;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    dmem_if ma();
    dmem_if mb();

    dmem_rsp #(.LATENCY(2)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ma));
    dmem_rsp #(.LATENCY(0)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(mb));

    always #5 clk = ~clk;

    function automatic logic cur_ready(input bit sel);
        return sel ? mb.req_ready : ma.req_ready;
    endfunction

    function automatic logic cur_valid(input bit sel);
        return sel ? mb.rsp_valid : ma.rsp_valid;
    endfunction

    task automatic set_req(input bit sel, input logic v, input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wstrb);
        if (sel) begin
            mb.req_valid = v; mb.req_wen = wen; mb.req_addr = addr; mb.req_wdata = wdata; mb.req_wstrb = wstrb;
        end else begin
            ma.req_valid = v; ma.req_wen = wen; ma.req_addr = addr; ma.req_wdata = wdata; ma.req_wstrb = wstrb;
        end
    endtask

    // One full transaction; request fields are scrambled right after the handshake.
    task automatic xfer(input bit sel, input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wstrb, output logic [63:0] rdata, output logic err, output int lat);
        int n = 0;
        set_req(sel, 1'b1, wen, addr, wdata, wstrb);
        ma.rsp_ready = 1'b1;
        mb.rsp_ready = 1'b1;
        while (!cur_ready(sel) && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        set_req(sel, 1'b0, ~wen, ~addr, ~wdata, ~wstrb);
        lat = 0;
        while (!cur_valid(sel) && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = sel ? mb.rsp_rdata : ma.rsp_rdata;
        err   = sel ? mb.rsp_err : ma.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        ma.rsp_ready = 1'b0;
        mb.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ma.req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", ma.req_ready); end
        checks++; if (ma.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", ma.rsp_valid); end
        checks++; if (ma.rsp_rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", ma.rsp_rdata); end
        checks++; if (ma.rsp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", ma.rsp_err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ma.req_ready !== 1'b1) begin failures++; $display("FAIL rel_req_ready got=%b exp=1", ma.req_ready); end
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic er; int lat;
        xfer(0, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL st_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 64'h0) begin failures++; $display("FAIL st_rdata got=%h exp=0", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL st_err got=%b exp=0", er); end
        xfer(0, 0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL ld_rdata got=%h exp=1122334455667788", rd); end
    endtask

    task automatic test_strobe();
        logic [63:0] rd; logic er; int lat;
        xfer(0, 1, 64'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, rd, er, lat);
        checks++; if (rd !== 64'h0) begin failures++; $display("FAIL strb_st_rdata got=%h exp=0", rd); end
        xfer(0, 0, 64'h8000_0017, 64'h0, 8'hFF, rd, er, lat);
        checks++; if (rd !== 64'h1122_3344_BBBB_BBBB) begin failures++; $display("FAIL strb_ld_rdata got=%h exp=11223344bbbbbbbb", rd); end
    endtask

    task automatic test_hold();
        int n = 0;
        set_req(0, 1, 0, 64'h8000_0010, '0, '0);
        ma.rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(0, 0, 1, 64'h8000_0018, '1, '1);
        while (!ma.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ma.rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, ma.rsp_valid); end
            checks++; if (ma.rsp_rdata !== 64'h1122_3344_BBBB_BBBB) begin failures++; $display("FAIL hold_rdata[%0d] got=%h exp=11223344bbbbbbbb", i, ma.rsp_rdata); end
            checks++; if (ma.req_ready !== 1'b0) begin failures++; $display("FAIL hold_req_ready[%0d] got=%b exp=0", i, ma.req_ready); end
            @(posedge clk); #1;
        end
        ma.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (ma.rsp_valid !== 1'b0) begin failures++; $display("FAIL hold_done_valid got=%b exp=0", ma.rsp_valid); end
        checks++; if (ma.req_ready !== 1'b1) begin failures++; $display("FAIL hold_done_ready got=%b exp=1", ma.req_ready); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic er; int lat;
        xfer(1, 1, 64'h8000_0100, 64'h0102_0304_0506_0708, 8'hFF, rd, er, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL l0_st_latency got=%0d exp=1", lat); end
        xfer(1, 1, 64'h8000_0108, 64'hF0E0_D0C0_B0A0_9080, 8'hFF, rd, er, lat);
        set_req(1, 1, 0, 64'h8000_0100, '0, '0);
        checks++; if (mb.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", mb.req_ready); end
        @(posedge clk); #1;
        mb.req_addr = 64'h8000_0108;
        checks++; if (mb.rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_t0 got=%b exp=0", mb.rsp_valid); end
        @(posedge clk); #1;
        checks++; if (mb.rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_t1 got=%b exp=1", mb.rsp_valid); end
        checks++; if (mb.rsp_rdata !== 64'h0102_0304_0506_0708) begin failures++; $display("FAIL b2b_rdata0 got=%h exp=0102030405060708", mb.rsp_rdata); end
        checks++; if (mb.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_resp got=%b exp=0", mb.req_ready); end
        @(posedge clk); #1;
        checks++; if (mb.rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_t2 got=%b exp=0", mb.rsp_valid); end
        checks++; if (mb.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", mb.req_ready); end
        @(posedge clk); #1;
        set_req(1, 0, 0, '0, '0, '0);
        checks++; if (mb.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept1 got=%b exp=0", mb.req_ready); end
        @(posedge clk); #1;
        checks++; if (mb.rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got=%b exp=1", mb.rsp_valid); end
        checks++; if (mb.rsp_rdata !== 64'hF0E0_D0C0_B0A0_9080) begin failures++; $display("FAIL b2b_rdata1 got=%h exp=f0e0d0c0b0a09080", mb.rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat;
        xfer(0, 1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat);
        set_req(0, 1, 1, 64'h8000_0020, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        @(posedge clk); #1;
        set_req(0, 0, 0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        checks++; if (ma.req_ready !== 1'b0) begin failures++; $display("FAIL mid_req_ready got=%b exp=0", ma.req_ready); end
        checks++; if (ma.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid got=%b exp=0", ma.rsp_valid); end
        checks++; if (ma.rsp_rdata !== 64'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", ma.rsp_rdata); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ma.req_ready !== 1'b1) begin failures++; $display("FAIL mid_rel_ready got=%b exp=1", ma.req_ready); end
        xfer(0, 0, 64'h8000_0020, '0, '0, rd, er, lat);
        checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL mid_old_word got=%h exp=0123456789abcdef", rd); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL mid_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_addr_range();
        logic [63:0] rd, exp_rd; logic er, exp_er; int lat;
`ifdef DMEM_ERR_EN
        exp_rd = 64'h0; exp_er = 1'b1;
`else
        exp_rd = 64'hCAFE_F00D_1234_5678; exp_er = 1'b0;
`endif
        xfer(0, 1, 64'h8000_0000, 64'hCAFE_F00D_1234_5678, 8'hFF, rd, er, lat);
        xfer(0, 0, 64'h8000_2000, '0, '0, rd, er, lat);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL range_rdata got=%h exp=%h", rd, exp_rd); end
        checks++; if (er !== exp_er) begin failures++; $display("FAIL range_err got=%b exp=%b", er, exp_er); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL range_latency got=%0d exp=3", lat); end
        xfer(0, 0, 64'h8000_0000, '0, '0, rd, er, lat);
        checks++; if (rd !== 64'hCAFE_F00D_1234_5678) begin failures++; $display("FAIL range_word0 got=%h exp=cafef00d12345678", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_strobe();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_addr_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
